// File: rtl/cpu31_pkg.sv
// cpu31_pkg: shared encodings for the CPU31 multi-cycle control path.
// Holds ALUC opcodes, MIPS opcode/funct values, datapath select codes,
// the control FSM state enum and the instruction-class enum.
package cpu31_pkg;

    // ALUC encodings, identical to the ALU's own decode
    localparam logic [3:0] ALUC_ADDU = 4'b0000;
    localparam logic [3:0] ALUC_SUBU = 4'b0001;
    localparam logic [3:0] ALUC_ADD  = 4'b0010;
    localparam logic [3:0] ALUC_SUB  = 4'b0011;
    localparam logic [3:0] ALUC_AND  = 4'b0100;
    localparam logic [3:0] ALUC_OR   = 4'b0101;
    localparam logic [3:0] ALUC_XOR  = 4'b0110;
    localparam logic [3:0] ALUC_NOR  = 4'b0111;
    localparam logic [3:0] ALUC_LUI  = 4'b1000;
    localparam logic [3:0] ALUC_SLTU = 4'b1010;
    localparam logic [3:0] ALUC_SLT  = 4'b1011;
    localparam logic [3:0] ALUC_SRA  = 4'b1100;
    localparam logic [3:0] ALUC_SRL  = 4'b1101;
    localparam logic [3:0] ALUC_SLL  = 4'b1110;

    // Primary opcodes, instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes, instr[5:0]
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // ALU operand A select
    localparam logic [1:0] ASEL_RS    = 2'd0;
    localparam logic [1:0] ASEL_SHAMT = 2'd1;
    localparam logic [1:0] ASEL_PC    = 2'd2;
    localparam logic [1:0] ASEL_RSLO  = 2'd3;
    // ALU operand B select
    localparam logic [1:0] BSEL_RT    = 2'd0;
    localparam logic [1:0] BSEL_SIMM  = 2'd1;
    localparam logic [1:0] BSEL_ZIMM  = 2'd2;
    localparam logic [1:0] BSEL_FOUR  = 2'd3;
    // Next-PC source
    localparam logic [1:0] PCSRC_ALU  = 2'd0;
    localparam logic [1:0] PCSRC_BR   = 2'd1;
    localparam logic [1:0] PCSRC_JMP  = 2'd2;
    localparam logic [1:0] PCSRC_RS   = 2'd3;
    // Register-file destination
    localparam logic [1:0] RFDST_RD   = 2'd0;
    localparam logic [1:0] RFDST_RT   = 2'd1;
    localparam logic [1:0] RFDST_RA   = 2'd2;
    // Register-file write data source
    localparam logic [1:0] RFSRC_ALU  = 2'd0;
    localparam logic [1:0] RFSRC_MEM  = 2'd1;
    localparam logic [1:0] RFSRC_PC   = 2'd2;
    localparam logic [1:0] RFSRC_NEG  = 2'd3;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } cu_state_e;

    // CL_NOP doubles as "unknown encoding"
    typedef enum logic [3:0] {
        CL_NOP = 4'd0,
        CL_ALU = 4'd1,
        CL_BEQ = 4'd2,
        CL_BNE = 4'd3,
        CL_J   = 4'd4,
        CL_JAL = 4'd5,
        CL_JR  = 4'd6,
        CL_LW  = 4'd7,
        CL_SW  = 4'd8
    } instr_class_e;

endpackage

// File: rtl/cu_decoder.sv
// cu_decoder: classifies an instruction and produces its ALU opcode and datapath selects.
// Latency: purely combinational. Backpressure: none, evaluated every cycle.
// Ports: i_opcode/i_funct in; o_class, o_alu_op, o_a_sel, o_b_sel, o_rf_dst,
//        o_rf_src, o_illegal (unknown opcode/funct) out.
module cu_decoder
    import cpu31_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output logic [3:0] o_class,
    output logic [3:0] o_alu_op,
    output logic [1:0] o_a_sel,
    output logic [1:0] o_b_sel,
    output logic [1:0] o_rf_dst,
    output logic [1:0] o_rf_src,
    output logic       o_illegal
);

    instr_class_e w_cls;

    always_comb begin
        w_cls    = CL_NOP;
        o_alu_op = ALUC_ADDU;
        o_a_sel  = ASEL_RS;
        o_b_sel  = BSEL_RT;
        o_rf_dst = RFDST_RD;
        o_rf_src = RFSRC_ALU;
        case (i_opcode)
            OP_RTYPE: begin
                case (i_funct)
                    FN_ADD:  begin w_cls = CL_ALU; o_alu_op = ALUC_ADD;  end
                    FN_ADDU: begin w_cls = CL_ALU; o_alu_op = ALUC_ADDU; end
                    FN_SUB:  begin w_cls = CL_ALU; o_alu_op = ALUC_SUB;  end
                    FN_SUBU: begin w_cls = CL_ALU; o_alu_op = ALUC_SUBU; end
                    FN_AND:  begin w_cls = CL_ALU; o_alu_op = ALUC_AND;  end
                    FN_OR:   begin w_cls = CL_ALU; o_alu_op = ALUC_OR;   end
                    FN_XOR:  begin w_cls = CL_ALU; o_alu_op = ALUC_XOR;  end
                    FN_NOR:  begin w_cls = CL_ALU; o_alu_op = ALUC_NOR;  end
                    FN_SLT:  begin w_cls = CL_ALU; o_alu_op = ALUC_SLT;  o_rf_src = RFSRC_NEG; end
                    FN_SLTU: begin w_cls = CL_ALU; o_alu_op = ALUC_SLTU; o_rf_src = RFSRC_NEG; end
                    // Constant shifts take the amount from shamt, variable ones from rs[4:0]
                    FN_SLL:  begin w_cls = CL_ALU; o_alu_op = ALUC_SLL; o_a_sel = ASEL_SHAMT; end
                    FN_SRL:  begin w_cls = CL_ALU; o_alu_op = ALUC_SRL; o_a_sel = ASEL_SHAMT; end
                    FN_SRA:  begin w_cls = CL_ALU; o_alu_op = ALUC_SRA; o_a_sel = ASEL_SHAMT; end
                    FN_SLLV: begin w_cls = CL_ALU; o_alu_op = ALUC_SLL; o_a_sel = ASEL_RSLO;  end
                    FN_SRLV: begin w_cls = CL_ALU; o_alu_op = ALUC_SRL; o_a_sel = ASEL_RSLO;  end
                    FN_SRAV: begin w_cls = CL_ALU; o_alu_op = ALUC_SRA; o_a_sel = ASEL_RSLO;  end
                    FN_JR:   begin w_cls = CL_JR; end
                    default: ;
                endcase
            end
            OP_ADDI:  begin w_cls = CL_ALU; o_alu_op = ALUC_ADD;  o_b_sel = BSEL_SIMM; o_rf_dst = RFDST_RT; end
            OP_ADDIU: begin w_cls = CL_ALU; o_alu_op = ALUC_ADDU; o_b_sel = BSEL_SIMM; o_rf_dst = RFDST_RT; end
            OP_SLTI:  begin w_cls = CL_ALU; o_alu_op = ALUC_SLT;  o_b_sel = BSEL_SIMM; o_rf_dst = RFDST_RT; o_rf_src = RFSRC_NEG; end
            OP_SLTIU: begin w_cls = CL_ALU; o_alu_op = ALUC_SLTU; o_b_sel = BSEL_SIMM; o_rf_dst = RFDST_RT; o_rf_src = RFSRC_NEG; end
            OP_ANDI:  begin w_cls = CL_ALU; o_alu_op = ALUC_AND;  o_b_sel = BSEL_ZIMM; o_rf_dst = RFDST_RT; end
            OP_ORI:   begin w_cls = CL_ALU; o_alu_op = ALUC_OR;   o_b_sel = BSEL_ZIMM; o_rf_dst = RFDST_RT; end
            OP_XORI:  begin w_cls = CL_ALU; o_alu_op = ALUC_XOR;  o_b_sel = BSEL_ZIMM; o_rf_dst = RFDST_RT; end
            OP_LUI:   begin w_cls = CL_ALU; o_alu_op = ALUC_LUI;  o_b_sel = BSEL_ZIMM; o_rf_dst = RFDST_RT; end
            OP_BEQ:   begin w_cls = CL_BEQ; o_alu_op = ALUC_SUBU; end
            OP_BNE:   begin w_cls = CL_BNE; o_alu_op = ALUC_SUBU; end
            OP_J:     begin w_cls = CL_J; end
            OP_JAL:   begin w_cls = CL_JAL; o_rf_dst = RFDST_RA; o_rf_src = RFSRC_PC; end
            OP_LW:    begin w_cls = CL_LW; o_b_sel = BSEL_SIMM; o_rf_dst = RFDST_RT; o_rf_src = RFSRC_MEM; end
            OP_SW:    begin w_cls = CL_SW; o_b_sel = BSEL_SIMM; end
            default: ;
        endcase
    end

    assign o_class   = w_cls;
    assign o_illegal = (w_cls == CL_NOP);

endmodule

// File: rtl/mc_ctrl_unit.sv
// mc_ctrl_unit: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the CPU31 MIPS core.
// Latency: ALU/LUI/SLT 4 cycles, LW 5, SW 4, branch/jump 3, plus one per memory wait cycle.
// Backpressure: stalls in FETCH/MEM until mem_ready; optional timeout via CU_MEM_WAIT_MAX.
// Ports: clk, rst (async, active-high), instr (IR), zero/negative (ALU flags), mem_ready in;
//        alu_op, alu_a_sel, alu_b_sel, pc_we, ir_we, rf_we, mem_req, mem_we, pc_src,
//        rf_dst, rf_src, illegal, mem_timeout out.
// Build option: define CU_ILLEGAL_TRAP_EN to trap unknown encodings into HALT with
//        illegal=1; otherwise they retire as NOPs and illegal stays 0.
module mc_ctrl_unit
    import cpu31_pkg::*;
#(
    parameter int unsigned CU_MEM_WAIT_MAX = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        negative,
    input  logic        mem_ready,
    output logic [3:0]  alu_op,
    output logic [1:0]  alu_a_sel,
    output logic [1:0]  alu_b_sel,
    output logic        pc_we,
    output logic        ir_we,
    output logic        rf_we,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  pc_src,
    output logic [1:0]  rf_dst,
    output logic [1:0]  rf_src,
    output logic        illegal,
    output logic        mem_timeout
);

    cu_state_e    r_state, w_next;
    instr_class_e r_class;
    logic [3:0]   r_alu_op;
    logic [1:0]   r_a_sel, r_b_sel, r_rf_dst, r_rf_src;
    logic [31:0]  r_wait;
    logic         r_timeout;

    logic [3:0]   w_dec_class, w_dec_alu_op;
    logic [1:0]   w_dec_a_sel, w_dec_b_sel, w_dec_rf_dst, w_dec_rf_src;
    logic         w_dec_illegal;

    logic [3:0]   w_alu_op;
    logic [1:0]   w_a_sel, w_b_sel, w_pc_src, w_rf_dst, w_rf_src;
    logic         w_pc_we, w_ir_we, w_rf_we, w_mem_req, w_mem_we;
    logic         w_waiting, w_wait_hit;

    // The datapath consumes negative directly via rf_src; the rest of instr is operand fields
    logic         w_unused;
    assign w_unused = ^{instr[25:6], negative};

    cu_decoder u_dec (
        .i_opcode  (instr[31:26]),
        .i_funct   (instr[5:0]),
        .o_class   (w_dec_class),
        .o_alu_op  (w_dec_alu_op),
        .o_a_sel   (w_dec_a_sel),
        .o_b_sel   (w_dec_b_sel),
        .o_rf_dst  (w_dec_rf_dst),
        .o_rf_src  (w_dec_rf_src),
        .o_illegal (w_dec_illegal)
    );

    // A wait cycle is one spent in a memory state without mem_ready
    assign w_waiting  = ((r_state == ST_FETCH) || (r_state == ST_MEM)) && !mem_ready;
    assign w_wait_hit = (CU_MEM_WAIT_MAX != 0) && w_waiting
                        && ((r_wait + 32'd1) == CU_MEM_WAIT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Decode results are captured on leaving DECODE and held through EXEC/MEM/WB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_class  <= CL_NOP;
            r_alu_op <= ALUC_ADDU;
            r_a_sel  <= ASEL_RS;
            r_b_sel  <= BSEL_RT;
            r_rf_dst <= RFDST_RD;
            r_rf_src <= RFSRC_ALU;
        end else if (r_state == ST_DECODE) begin
            r_class  <= instr_class_e'(w_dec_class);
            r_alu_op <= w_dec_alu_op;
            r_a_sel  <= w_dec_a_sel;
            r_b_sel  <= w_dec_b_sel;
            r_rf_dst <= w_dec_rf_dst;
            r_rf_src <= w_dec_rf_src;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait    <= 32'd0;
            r_timeout <= 1'b0;
        end else begin
            if (w_waiting && (CU_MEM_WAIT_MAX != 0)) begin
                r_wait <= r_wait + 32'd1;
            end else begin
                r_wait <= 32'd0;
            end
            if (w_wait_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end

`ifdef CU_ILLEGAL_TRAP_EN
    logic r_illegal;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illegal <= 1'b0;
        end else if ((r_state == ST_DECODE) && w_dec_illegal) begin
            r_illegal <= 1'b1;
        end
    end
    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif

    always_comb begin
        w_next    = r_state;
        w_alu_op  = r_alu_op;
        w_a_sel   = r_a_sel;
        w_b_sel   = r_b_sel;
        w_rf_dst  = r_rf_dst;
        w_rf_src  = r_rf_src;
        w_pc_src  = PCSRC_ALU;
        w_pc_we   = 1'b0;
        w_ir_we   = 1'b0;
        w_rf_we   = 1'b0;
        w_mem_req = 1'b0;
        w_mem_we  = 1'b0;
        case (r_state)
            ST_FETCH: begin
                // ALU computes PC+4 while the instruction is fetched
                w_mem_req = 1'b1;
                w_alu_op  = ALUC_ADDU;
                w_a_sel   = ASEL_PC;
                w_b_sel   = BSEL_FOUR;
                w_rf_dst  = RFDST_RD;
                w_rf_src  = RFSRC_ALU;
                if (mem_ready) begin
                    w_ir_we = 1'b1;
                    w_pc_we = 1'b1;
                    w_next  = ST_DECODE;
                end else if (w_wait_hit) begin
                    w_next  = ST_HALT;
                end
            end
            ST_DECODE: begin
                w_alu_op = w_dec_alu_op;
                w_a_sel  = w_dec_a_sel;
                w_b_sel  = w_dec_b_sel;
                w_rf_dst = w_dec_rf_dst;
                w_rf_src = w_dec_rf_src;
                if (w_dec_illegal) begin
`ifdef CU_ILLEGAL_TRAP_EN
                    w_next = ST_HALT;
`else
                    w_next = ST_FETCH;
`endif
                end else begin
                    w_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_next = ST_FETCH;
                case (r_class)
                    CL_ALU: w_next = ST_WB;
                    CL_BEQ: if (zero)  begin w_pc_we = 1'b1; w_pc_src = PCSRC_BR; end
                    CL_BNE: if (!zero) begin w_pc_we = 1'b1; w_pc_src = PCSRC_BR; end
                    CL_J:   begin w_pc_we = 1'b1; w_pc_src = PCSRC_JMP; end
                    // Link register write rides on the jump cycle; selects come from decode
                    CL_JAL: begin w_pc_we = 1'b1; w_pc_src = PCSRC_JMP; w_rf_we = 1'b1; end
                    CL_JR:  begin w_pc_we = 1'b1; w_pc_src = PCSRC_RS; end
                    CL_LW,
                    CL_SW:  w_next = ST_MEM;
                    default: ;
                endcase
            end
            ST_MEM: begin
                w_mem_req = 1'b1;
                w_mem_we  = (r_class == CL_SW);
                if (mem_ready) begin
                    w_next = (r_class == CL_LW) ? ST_WB : ST_FETCH;
                end else if (w_wait_hit) begin
                    w_next = ST_HALT;
                end
            end
            ST_WB: begin
                w_rf_we = 1'b1;
                w_next  = ST_FETCH;
            end
            ST_HALT: ;
            default: w_next = ST_FETCH;
        endcase
    end

    // Gating with rst drops every output asynchronously, abandoning any in-flight write
    assign alu_op      = rst ? 4'd0 : w_alu_op;
    assign alu_a_sel   = rst ? 2'd0 : w_a_sel;
    assign alu_b_sel   = rst ? 2'd0 : w_b_sel;
    assign pc_src      = rst ? 2'd0 : w_pc_src;
    assign rf_dst      = rst ? 2'd0 : w_rf_dst;
    assign rf_src      = rst ? 2'd0 : w_rf_src;
    assign pc_we       = !rst && w_pc_we;
    assign ir_we       = !rst && w_ir_we;
    assign rf_we       = !rst && w_rf_we;
    assign mem_req     = !rst && w_mem_req;
    assign mem_we      = !rst && w_mem_we;
    assign mem_timeout = r_timeout;

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// tb_mc_ctrl_unit: directed bench for mc_ctrl_unit with an expected-output scoreboard.
// Each instruction pushes its per-cycle expected outputs; each cycle pops and compares.
// Runs with CU_MEM_WAIT_MAX=8; illegal-opcode expectations follow CU_ILLEGAL_TRAP_EN.
module tb_mc_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        zero, negative, mem_ready;
    logic [3:0]  alu_op;
    logic [1:0]  alu_a_sel, alu_b_sel, pc_src, rf_dst, rf_src;
    logic        pc_we, ir_we, rf_we, mem_req, mem_we, illegal, mem_timeout;

    mc_ctrl_unit #(.CU_MEM_WAIT_MAX(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .zero        (zero),
        .negative    (negative),
        .mem_ready   (mem_ready),
        .alu_op      (alu_op),
        .alu_a_sel   (alu_a_sel),
        .alu_b_sel   (alu_b_sel),
        .pc_we       (pc_we),
        .ir_we       (ir_we),
        .rf_we       (rf_we),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .pc_src      (pc_src),
        .rf_dst      (rf_dst),
        .rf_src      (rf_src),
        .illegal     (illegal),
        .mem_timeout (mem_timeout)
    );

    always #5 clk = ~clk;

    // Observation word: [20:17] alu_op [16:15] a_sel [14:13] b_sel
    // [12:8] {pc_we, ir_we, rf_we, mem_req, mem_we} [7:6] pc_src [5:4] rf_dst
    // [3:2] rf_src [1] illegal [0] mem_timeout
    logic [20:0] obs;
    assign obs = {alu_op, alu_a_sel, alu_b_sel, pc_we, ir_we, rf_we, mem_req, mem_we,
                  pc_src, rf_dst, rf_src, illegal, mem_timeout};

    localparam logic [20:0] M_ALL = 21'h1FFFFF;
    localparam logic [20:0] M_STB = 21'h001F03;  // strobes and sticky flags
    localparam logic [20:0] M_ALU = 21'h1FE000;
    localparam logic [20:0] M_PCS = 21'h0000C0;
    localparam logic [20:0] M_DST = 21'h000030;
    localparam logic [20:0] M_SRC = 21'h00000C;

    // Strobe groups {pc_we, ir_we, rf_we, mem_req, mem_we}
    localparam logic [4:0] S_NONE  = 5'b00000;
    localparam logic [4:0] S_FETCH = 5'b11010;
    localparam logic [4:0] S_REQ   = 5'b00010;
    localparam logic [4:0] S_SW    = 5'b00011;
    localparam logic [4:0] S_RF    = 5'b00100;
    localparam logic [4:0] S_PC    = 5'b10000;
    localparam logic [4:0] S_JAL   = 5'b10100;

    typedef struct {
        string       tag;
        logic [20:0] val;
        logic [20:0] mask;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic logic [20:0] v(input logic [3:0] alu, input logic [1:0] a, input logic [1:0] b,
                                      input logic [4:0] stb, input logic [1:0] pcs,
                                      input logic [1:0] dst, input logic [1:0] src,
                                      input logic [1:0] flg);
        return {alu, a, b, stb, pcs, dst, src, flg};
    endfunction

    task automatic push(input string tag, input logic [20:0] val, input logic [20:0] mask);
        exp_t e;
        e.tag  = tag;
        e.val  = val;
        e.mask = mask;
        sb.push_back(e);
    endtask

    task automatic compare_head();
        exp_t e;
        n_chk++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_underflow observed=%h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert ((obs & e.mask) === (e.val & e.mask)) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h (mask %h)",
                       e.tag, obs & e.mask, e.val & e.mask, e.mask);
            end
        end
    endtask

    // One clock: apply mem_ready, compare on the falling edge, advance past the rising edge
    task automatic cycle(input logic mr);
        mem_ready = mr;
        @(negedge clk);
        compare_head();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input logic [15:0] mr_bits);
        for (int i = 0; i < n; i++) cycle(mr_bits[i]);
    endtask

    task automatic push_fetch(input string tag);
        push(tag, v(4'b0000, 2'd2, 2'd3, S_FETCH, 2'd0, 2'd0, 2'd0, 2'b00), M_STB | M_ALU | M_PCS);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; instr = 32'h0; zero = 1'b0; negative = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1;

        // Held in reset with mem_ready high: every output low
        push("reset_outputs", 21'h0, M_ALL);
        run(1, 16'hFFFF);
        rst = 1'b0;

        // ADDU $3,$1,$2
        instr = 32'h00221821;
        push_fetch("addu_fetch");
        push("addu_decode", 21'h0, M_STB);
        push("addu_exec", v(4'b0000, 2'd0, 2'd0, S_NONE, 2'd0, 2'd0, 2'd0, 2'b00), M_STB | M_ALU);
        push("addu_wb", v(4'b0000, 2'd0, 2'd0, S_RF, 2'd0, 2'd0, 2'd0, 2'b00), M_STB | M_ALU | M_DST | M_SRC);
        run(4, 16'hFFFF);

        // SLTI $2,$1,5
        instr = 32'h28220005;
        push_fetch("slti_fetch");
        push("slti_decode", 21'h0, M_STB);
        push("slti_exec", v(4'b1011, 2'd0, 2'd1, S_NONE, 2'd0, 2'd0, 2'd0, 2'b00), M_STB | M_ALU);
        push("slti_wb", v(4'b1011, 2'd0, 2'd1, S_RF, 2'd0, 2'd1, 2'd3, 2'b00), M_STB | M_ALU | M_DST | M_SRC);
        run(4, 16'hFFFF);

        // BEQ taken / not taken, BNE taken / not taken
        instr = 32'h10220003; zero = 1'b1;
        push_fetch("beq_z1_fetch");
        push("beq_z1_decode", 21'h0, M_STB);
        push("beq_z1_exec", v(4'b0001, 2'd0, 2'd0, S_PC, 2'd1, 2'd0, 2'd0, 2'b00), M_STB | M_ALU | M_PCS);
        run(3, 16'hFFFF);
        zero = 1'b0;
        push_fetch("beq_z0_fetch");
        push("beq_z0_decode", 21'h0, M_STB);
        push("beq_z0_exec", v(4'b0001, 2'd0, 2'd0, S_NONE, 2'd0, 2'd0, 2'd0, 2'b00), M_STB | M_ALU);
        run(3, 16'hFFFF);
        instr = 32'h14220003;
        push_fetch("bne_z0_fetch");
        push("bne_z0_decode", 21'h0, M_STB);
        push("bne_z0_exec", v(4'b0001, 2'd0, 2'd0, S_PC, 2'd1, 2'd0, 2'd0, 2'b00), M_STB | M_ALU | M_PCS);
        run(3, 16'hFFFF);
        zero = 1'b1;
        push_fetch("bne_z1_fetch");
        push("bne_z1_decode", 21'h0, M_STB);
        push("bne_z1_exec", 21'h0, M_STB);
        run(3, 16'hFFFF);
        zero = 1'b0;

        // J, JAL, JR
        instr = 32'h08000010;
        push_fetch("j_fetch");
        push("j_decode", 21'h0, M_STB);
        push("j_exec", v(4'b0000, 2'd0, 2'd0, S_PC, 2'd2, 2'd0, 2'd0, 2'b00), M_STB | M_PCS);
        run(3, 16'hFFFF);
        instr = 32'h0C000010;
        push_fetch("jal_fetch");
        push("jal_decode", 21'h0, M_STB);
        push("jal_exec", v(4'b0000, 2'd0, 2'd0, S_JAL, 2'd2, 2'd2, 2'd2, 2'b00), M_STB | M_PCS | M_DST | M_SRC);
        run(3, 16'hFFFF);
        instr = 32'h00200008;
        push_fetch("jr_fetch");
        push("jr_decode", 21'h0, M_STB);
        push("jr_exec", v(4'b0000, 2'd0, 2'd0, S_PC, 2'd3, 2'd0, 2'd0, 2'b00), M_STB | M_PCS);
        run(3, 16'hFFFF);

        // LW with three wait cycles in MEM: rf write lands on cycle 8
        instr = 32'h8C220004;
        push_fetch("lw_fetch");
        push("lw_decode", 21'h0, M_STB);
        push("lw_exec", v(4'b0000, 2'd0, 2'd1, S_NONE, 2'd0, 2'd0, 2'd0, 2'b00), M_STB | M_ALU);
        push("lw_mem_wait1", v(4'b0000, 2'd0, 2'd1, S_REQ, 2'd0, 2'd0, 2'd0, 2'b00), M_STB | M_ALU);
        push("lw_mem_wait2", v(4'b0000, 2'd0, 2'd1, S_REQ, 2'd0, 2'd0, 2'd0, 2'b00), M_STB | M_ALU);
        push("lw_mem_wait3", v(4'b0000, 2'd0, 2'd1, S_REQ, 2'd0, 2'd0, 2'd0, 2'b00), M_STB | M_ALU);
        push("lw_mem_done", v(4'b0000, 2'd0, 2'd1, S_REQ, 2'd0, 2'd0, 2'd0, 2'b00), M_STB | M_ALU);
        push("lw_wb", v(4'b0000, 2'd0, 2'd0, S_RF, 2'd0, 2'd1, 2'd1, 2'b00), M_STB | M_DST | M_SRC);
        run(8, 16'h00C7);

        // SW zero-wait: mem_we only in MEM
        instr = 32'hAC220004;
        push_fetch("sw_fetch");
        push("sw_decode", 21'h0, M_STB);
        push("sw_exec", v(4'b0000, 2'd0, 2'd1, S_NONE, 2'd0, 2'd0, 2'd0, 2'b00), M_STB | M_ALU);
        push("sw_mem", 21'h0 | v(4'b0000, 2'd0, 2'd0, S_SW, 2'd0, 2'd0, 2'd0, 2'b00), M_STB);
        run(4, 16'hFFFF);

        // Unknown opcode 0x3F
        instr = 32'hFC000000;
        push_fetch("ill_fetch");
        push("ill_decode", 21'h0, M_STB);
`ifdef CU_ILLEGAL_TRAP_EN
        push("ill_halt1", v(4'b0000, 2'd0, 2'd0, S_NONE, 2'd0, 2'd0, 2'd0, 2'b10), M_STB);
        push("ill_halt2", v(4'b0000, 2'd0, 2'd0, S_NONE, 2'd0, 2'd0, 2'd0, 2'b10), M_STB);
        run(4, 16'hFFFF);
`else
        push_fetch("ill_nop_refetch");
        run(3, 16'hFFFF);
`endif

        // Reset clears flags and state
        rst = 1'b1;
        push("reset2_outputs", 21'h0, M_ALL);
        run(1, 16'hFFFF);
        rst = 1'b0;

        // SW stalled in MEM, then asynchronous reset mid-access
        instr = 32'hAC220004;
        push_fetch("sws_fetch");
        push("sws_decode", 21'h0, M_STB);
        push("sws_exec", 21'h0, M_STB);
        push("sws_mem_wait1", v(4'b0000, 2'd0, 2'd0, S_SW, 2'd0, 2'd0, 2'd0, 2'b00), M_STB);
        run(4, 16'h0007);
        mem_ready = 1'b0;
        #2;
        push("sws_mem_wait2", v(4'b0000, 2'd0, 2'd0, S_SW, 2'd0, 2'd0, 2'd0, 2'b00), M_STB);
        compare_head();
        rst = 1'b1;
        #1;
        push("rst_async_drop", 21'h0, M_ALL);
        compare_head();
        @(posedge clk); #1;
        rst = 1'b0;

        // mem_ready stuck low: 8 waiting FETCH cycles, then timeout and HALT
        for (int i = 1; i <= 8; i++)
            push($sformatf("tmo_wait%0d", i), v(4'b0000, 2'd2, 2'd3, S_REQ, 2'd0, 2'd0, 2'd0, 2'b00), M_STB | M_ALU);
        push("tmo_halt1", v(4'b0000, 2'd0, 2'd0, S_NONE, 2'd0, 2'd0, 2'd0, 2'b01), M_STB);
        push("tmo_halt2", v(4'b0000, 2'd0, 2'd0, S_NONE, 2'd0, 2'd0, 2'd0, 2'b01), M_STB);
        run(10, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
